// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one 24x24 mantissa multiplier among NREQ FPU sequencers.
// Grants one requester at a time, forwards latched operands, returns the product, and aborts on a silent multiplier.
module booth_mul_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic [NREQ-1:0]    Req_valid,
  input  logic [NREQ*24-1:0] Req_datain1,
  input  logic [NREQ*24-1:0] Req_datain2,
  output logic [NREQ-1:0]    Req_ack,
  output logic               Req_err,
  output logic [47:0]        Req_dataout,
  output logic [23:0]        Multi_datain1,
  output logic [23:0]        Multi_datain2,
  output logic               Multi_valid,
  input  logic [47:0]        Multi_dataout,
  input  logic               Multi_ack,
  output logic               Busy,
  output logic [2:0]         Grant_id
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RESPOND  = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [23:0]     a_q, a_d;
  logic [23:0]     b_q, b_d;
  logic            mv_q, mv_d;
  logic [2:0]      gid_q, gid_d;
  logic [2:0]      last_q, last_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic [47:0]     res_q, res_d;

  logic [2:0]      win;
  logic [23:0]     sel_a;
  logic [23:0]     sel_b;

  // First requester strictly after 'last' (wrapping), else lowest-index requester.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] req, input logic [2:0] last);
    logic [NREQ-1:0] hi;
    logic [NREQ-1:0] src;
    logic [2:0]      pick;
    for (int i = 0; i < NREQ; i++) begin
      hi[i] = req[i] && (i > int'(last));
    end
    src  = (|hi) ? hi : req;
    pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (src[i]) pick = 3'(i);
    end
    return pick;
  endfunction

  always_comb begin
    win   = rr_pick(Req_valid, last_q);
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == 3'(i)) begin
        sel_a = Req_datain1[24*i +: 24];
        sel_b = Req_datain2[24*i +: 24];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mv_d    = mv_q;
    gid_d   = gid_q;
    last_d  = last_q;
    wd_d    = wd_q;
    err_d   = err_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (|Req_valid) begin
          gid_d   = win;
          last_d  = win;
          a_d     = sel_a;
          b_d     = sel_b;
          mv_d    = 1'b1;
          wd_d    = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // A real ack wins over a watchdog expiry in the same cycle.
        if (Multi_ack) begin
          res_d   = Multi_dataout;
          err_d   = 1'b0;
          mv_d    = 1'b0;
          state_d = RESPOND;
        end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
          res_d   = '0;
          err_d   = 1'b1;
          mv_d    = 1'b0;
          state_d = RESPOND;
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESPOND: state_d = DRAIN;
      DRAIN: begin
        if (!Multi_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mv_q    <= 1'b0;
      gid_q   <= '0;
      last_q  <= 3'(NREQ - 1);
      wd_q    <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mv_q    <= mv_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Result is pure data and only observed through the RESPOND-gated outputs.
  always_ff @(posedge CLK) begin
    res_q <= res_d;
  end

  always_comb begin
    Req_ack = '0;
    for (int i = 0; i < NREQ; i++) begin
      Req_ack[i] = (state_q == RESPOND) && (gid_q == 3'(i));
    end
  end

  assign Req_err       = (state_q == RESPOND) && err_q;
  assign Req_dataout   = (state_q == RESPOND) ? res_q : '0;
  assign Multi_datain1 = a_q;
  assign Multi_datain2 = b_q;
  assign Multi_valid   = mv_q;
  assign Busy          = busy_q;
  assign Grant_id      = gid_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter: behavioural multiplier responder plus
// expected-ack queue filled as requests are driven and drained as Req_ack pulses appear.
module tb_booth_mul_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  logic               CLK = 1'b0;
  logic               RSTn;
  logic [NREQ-1:0]    Req_valid;
  logic [NREQ*24-1:0] Req_datain1;
  logic [NREQ*24-1:0] Req_datain2;
  logic [NREQ-1:0]    Req_ack;
  logic               Req_err;
  logic [47:0]        Req_dataout;
  logic [23:0]        Multi_datain1;
  logic [23:0]        Multi_datain2;
  logic               Multi_valid;
  logic [47:0]        Multi_dataout;
  logic               Multi_ack;
  logic               Busy;
  logic [2:0]         Grant_id;

  always #5 CLK = ~CLK;

  booth_mul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .Req_valid(Req_valid), .Req_datain1(Req_datain1), .Req_datain2(Req_datain2),
    .Req_ack(Req_ack), .Req_err(Req_err), .Req_dataout(Req_dataout),
    .Multi_datain1(Multi_datain1), .Multi_datain2(Multi_datain2), .Multi_valid(Multi_valid),
    .Multi_dataout(Multi_dataout), .Multi_ack(Multi_ack),
    .Busy(Busy), .Grant_id(Grant_id)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    int          id;
    logic [47:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [23:0] opa[NREQ];
  logic [23:0] opb[NREQ];

  // Multiplier model: ack after ack_delay cycles of Multi_valid, hold ack_hold cycles.
  int ack_delay = 1;
  int ack_hold  = 1;
  bit never_ack = 1'b0;
  int vcnt      = 0;
  int hold_cnt  = 0;

  initial begin
    Multi_ack     = 1'b0;
    Multi_dataout = 48'hBAD0_BAD0_BAD0;
    forever begin
      @(negedge CLK);
      if (Multi_ack) begin
        hold_cnt--;
        if (hold_cnt <= 0) begin
          Multi_ack     = 1'b0;
          Multi_dataout = 48'hBAD0_BAD0_BAD0;
        end
      end else if (Multi_valid && !never_ack) begin
        vcnt++;
        if (vcnt >= ack_delay) begin
          Multi_ack     = 1'b1;
          Multi_dataout = {24'h0, Multi_datain1} * {24'h0, Multi_datain2};
          hold_cnt      = ack_hold;
          vcnt          = 0;
        end
      end else begin
        vcnt = 0;
      end
    end
  end

  int   ack_count  = 0;
  int   mv_len     = 0;
  int   exp_mv_len = 0;
  exp_t mon_e;

  always @(posedge CLK) begin
    #1;
    if (RSTn) begin
      if (Multi_valid) begin
        mv_len++;
      end else if (mv_len != 0) begin
        if (exp_mv_len != 0) chk("mv_len", mv_len, exp_mv_len);
        mv_len = 0;
      end
      if (Req_ack != '0) begin
        ack_count++;
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", Req_ack, 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("ack_vec", Req_ack, 64'(1) << mon_e.id);
          chk("grant_id", Grant_id, mon_e.id);
          chk("dataout", Req_dataout, mon_e.data);
          chk("err", Req_err, mon_e.err);
          if (!mon_e.err) chk("ack_latency", Multi_ack, 1);
        end
      end
    end else begin
      mv_len = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic set_ops(input int i, input logic [23:0] a, input logic [23:0] b);
    opa[i] = a;
    opb[i] = b;
    Req_datain1[24*i +: 24] = a;
    Req_datain2[24*i +: 24] = b;
  endtask

  task automatic push(input int id, input logic err);
    exp_t e;
    e.id   = id;
    e.err  = err;
    e.data = err ? 48'h0 : ({24'h0, opa[id]} * {24'h0, opb[id]});
    sb_q.push_back(e);
  endtask

  task automatic wait_acks(input int target, input int budget);
    int c = 0;
    while (ack_count < target && c < budget) begin
      step(1);
      c++;
    end
    chk("ack_count", ack_count, target);
  endtask

  task automatic do_reset();
    RSTn      = 1'b0;
    Req_valid = '0;
    step(2);
    RSTn = 1'b1;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RSTn        = 1'b0;
    Req_valid   = '0;
    Req_datain1 = '0;
    Req_datain2 = '0;
    for (int i = 0; i < NREQ; i++) set_ops(i, 24'(i * 24'h010203 + 24'h000101), 24'(24'h0A0B0C - i * 24'h000303));
    step(2);
    chk("rst_mvalid", Multi_valid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_gid", Grant_id, 0);
    chk("rst_ack", Req_ack, 0);
    chk("rst_err", Req_err, 0);
    chk("rst_dout", Req_dataout, 0);
    chk("rst_opa", Multi_datain1, 0);
    chk("rst_opb", Multi_datain2, 0);
    RSTn = 1'b1;
    step(1);

    // Single transaction, ack three cycles after Multi_valid rises.
    set_ops(0, 24'hC00000, 24'h800000);
    ack_delay  = 3;
    exp_mv_len = 3;
    push(0, 1'b0);
    chk("t1_model", sb_q[0].data, 48'h600000000000);
    Req_valid = 4'b0001;
    step(1);
    chk("t1_mvalid", Multi_valid, 1);
    chk("t1_busy", Busy, 1);
    chk("t1_opa", Multi_datain1, 24'hC00000);
    set_ops(0, 24'h123456, 24'h654321);
    Req_valid = '0;
    step(1);
    chk("t1_opa_held", Multi_datain1, 24'hC00000);
    chk("t1_opb_held", Multi_datain2, 24'h800000);
    wait_acks(ack_count + 1, 20);
    step(3);
    chk("t1_idle", Busy, 0);

    // Two requesters held: alternate grants from reset.
    do_reset();
    ack_delay  = 1;
    exp_mv_len = 1;
    set_ops(0, 24'hFFFFFF, 24'hFFFFFF);
    set_ops(1, 24'h000001, 24'h7FFFFF);
    push(0, 1'b0); push(1, 1'b0); push(0, 1'b0); push(1, 1'b0);
    Req_valid = 4'b0011;
    wait_acks(ack_count + 4, 100);
    Req_valid = '0;
    step(4);

    // Sparse request pattern 1011: requester 2 is skipped.
    do_reset();
    ack_delay  = 2;
    exp_mv_len = 2;
    set_ops(3, 24'hABCDEF, 24'h13579B);
    push(0, 1'b0); push(1, 1'b0); push(3, 1'b0);
    push(0, 1'b0); push(1, 1'b0); push(3, 1'b0);
    Req_valid = 4'b1011;
    wait_acks(ack_count + 6, 150);
    Req_valid = '0;
    step(4);

    // Watchdog abort, then a normal request, then an ack on the last allowed cycle.
    never_ack  = 1'b1;
    exp_mv_len = TIMEOUT;
    set_ops(2, 24'h400000, 24'h000003);
    push(2, 1'b1);
    Req_valid = 4'b0100;
    wait_acks(ack_count + 1, 40);
    Req_valid = '0;
    never_ack = 1'b0;
    step(3);
    ack_delay  = 1;
    exp_mv_len = 1;
    push(2, 1'b0);
    Req_valid = 4'b0100;
    wait_acks(ack_count + 1, 20);
    Req_valid = '0;
    step(3);
    ack_delay  = TIMEOUT;
    exp_mv_len = TIMEOUT;
    set_ops(2, 24'h800001, 24'h800001);
    push(2, 1'b0);
    Req_valid = 4'b0100;
    wait_acks(ack_count + 1, 40);
    Req_valid = '0;
    step(3);

    // Lingering ack holds the arbiter in DRAIN; pending requester waits.
    ack_delay  = 1;
    ack_hold   = 5;
    exp_mv_len = 1;
    push(0, 1'b0); push(1, 1'b0);
    Req_valid = 4'b0011;
    wait_acks(ack_count + 1, 20);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("t5_drain_mvalid", Multi_valid, 0);
      chk("t5_drain_busy", Busy, 1);
    end
    wait_acks(ack_count + 1, 30);
    Req_valid = '0;
    ack_hold  = 1;
    step(8);

    // Reset during WAIT_ACK abandons the transaction; requester 0 wins afterwards.
    never_ack  = 1'b1;
    exp_mv_len = 0;
    Req_valid  = 4'b0010;
    step(1);
    chk("t6_mvalid", Multi_valid, 1);
    step(2);
    chk("t6_wait_busy", Busy, 1);
    RSTn      = 1'b0;
    Req_valid = 4'b1001;
    step(1);
    chk("t6_mvalid_rst", Multi_valid, 0);
    chk("t6_busy_rst", Busy, 0);
    chk("t6_ack_rst", Req_ack, 0);
    chk("t6_gid_rst", Grant_id, 0);
    chk("t6_opa_rst", Multi_datain1, 0);
    chk("t6_opb_rst", Multi_datain2, 0);
    chk("t6_err_rst", Req_err, 0);
    chk("t6_dout_rst", Req_dataout, 0);
    never_ack = 1'b0;
    ack_delay = 1;
    push(0, 1'b0);
    RSTn = 1'b1;
    wait_acks(ack_count + 1, 20);
    Req_valid = '0;
    step(6);

    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
